// File: rtl/uart_rx_cfg_pkg.sv
// Shared definitions for the configurable UART receiver: parity modes,
// receive FSM states and the oversampling tick divider computation.
package uart_rx_cfg_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rxState_t;

   // Rounded clocks-per-tick, never below one so the divider always advances.
   function automatic int calcDiv(input longint clockHz, input longint baud,
                                  input longint oversample);
      longint ticksPerSec;
      longint d;
      ticksPerSec = baud * oversample;
      d = (clockHz + ticksPerSec / 2) / ticksPerSec;
      return (d < 1) ? 1 : int'(d);
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, oversampling tick divider, per-bit sample counter and
// 3-sample mid-bit majority vote for the UART receiver.
module uart_rx_sampler #(
   parameter int DIV        = 10,
   parameter int OVERSAMPLE = 16
) (
   input  logic Clk,
   input  logic Reset,
   input  logic i_rxWire,
   input  logic i_run,
   output logic o_rxSync,
   output logic o_bitStrobe,
   output logic o_bitValue,
   output logic o_bitEnd
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int M  = OVERSAMPLE / 2;

   logic [1:0]    r_sync;
   logic [DW-1:0] r_divCount;
   logic [CW-1:0] r_sampleCount;
   logic [1:0]    r_samples;
   logic          w_tick;
   logic          w_lastCount;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_sync <= 2'b11;
      end else begin
         r_sync <= {r_sync[0], i_rxWire};
      end
   end

   assign o_rxSync    = r_sync[1];
   assign w_tick      = i_run && (r_divCount == DW'(DIV - 1));
   assign w_lastCount = (r_sampleCount == CW'(OVERSAMPLE - 1));

   // Counters sit at zero while idle so the bit phase starts at the start edge.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_divCount    <= '0;
         r_sampleCount <= '0;
      end else if (!i_run) begin
         r_divCount    <= '0;
         r_sampleCount <= '0;
      end else begin
         r_divCount <= w_tick ? '0 : r_divCount + 1'b1;
         if (w_tick) begin
            r_sampleCount <= w_lastCount ? '0 : r_sampleCount + 1'b1;
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_samples <= 2'b11;
      end else if (w_tick && ((r_sampleCount == CW'(M - 1)) ||
                              (r_sampleCount == CW'(M)))) begin
         r_samples <= {r_samples[0], o_rxSync};
      end
   end

   assign o_bitStrobe = w_tick && (r_sampleCount == CW'(M + 1));
   assign o_bitValue  = (r_samples[1] & r_samples[0]) |
                        (r_samples[1] & o_rxSync)     |
                        (r_samples[0] & o_rxSync);
   assign o_bitEnd    = w_tick && w_lastCount;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: frame FSM, data shift register, parity and
// framing checks, valid/ready holding register and sticky overrun flag.
module uart_rx_cfg
   import uart_rx_cfg_pkg::*;
#(
   parameter int CLOCK_FREQUENCY = 1_000_000,
   parameter int BAUD_RATE       = 9600,
   parameter int OVERSAMPLE      = 16,
   parameter int DATA_BITS       = 8,
   parameter int PARITY_MODE     = 0,
   parameter int STOP_BITS       = 1
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 RxWire,
   input  logic                 RxEnable,
   output logic [DATA_BITS-1:0] RxData,
   output logic                 RxValid,
   input  logic                 RxReady,
   output logic                 RxParityError,
   output logic                 RxFrameError,
   output logic                 RxBreak,
   output logic                 RxOverrun,
   input  logic                 RxErrorClear
);

   localparam int DIV = calcDiv(CLOCK_FREQUENCY, BAUD_RATE, OVERSAMPLE);

   rxState_t             r_state;
   rxState_t             w_nextState;
   logic                 w_rxSync;
   logic                 w_bitStrobe;
   logic                 w_bitValue;
   logic                 w_bitEnd;
   logic [3:0]           r_bitCount;
   logic                 r_stopCount;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_parBit;
   logic                 r_parErr;
   logic                 r_frameErr;
   logic                 r_needHigh;
   logic                 w_lastData;
   logic                 w_lastStop;
   logic                 w_expParity;
   logic                 w_complete;
   logic                 w_frameErrNow;
   logic                 w_breakNow;
   logic                 w_load;
   logic [DATA_BITS-1:0] r_rxData;
   logic                 r_rxValid;
   logic                 r_rxParityError;
   logic                 r_rxFrameError;
   logic                 r_rxBreak;
   logic                 r_rxOverrun;

   uart_rx_sampler #(
      .DIV        (DIV),
      .OVERSAMPLE (OVERSAMPLE)
   ) u_sampler (
      .Clk         (Clk),
      .Reset       (Reset),
      .i_rxWire    (RxWire),
      .i_run       (r_state != ST_IDLE),
      .o_rxSync    (w_rxSync),
      .o_bitStrobe (w_bitStrobe),
      .o_bitValue  (w_bitValue),
      .o_bitEnd    (w_bitEnd)
   );

   assign w_lastData    = (r_bitCount == 4'(DATA_BITS - 1));
   assign w_lastStop    = (r_stopCount == 1'(STOP_BITS - 1));
   assign w_expParity   = (PARITY_MODE == PARITY_ODD) ? ~(^r_shift) : ^r_shift;
   assign w_frameErrNow = r_frameErr | ~w_bitValue;
   assign w_breakNow    = (r_shift == '0) &&
                          ((PARITY_MODE == PARITY_NONE) || !r_parBit) &&
                          w_frameErrNow;
   assign w_load        = w_complete && (!r_rxValid || RxReady);

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // The frame completes at the mid-bit vote of the last stop bit so a
   // back-to-back start edge is never missed.
   always_comb begin
      w_nextState = r_state;
      w_complete  = 1'b0;
      if (!RxEnable) begin
         w_nextState = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (!w_rxSync && !r_needHigh) w_nextState = ST_START;
            end
            ST_START: begin
               if (w_bitStrobe && w_bitValue) w_nextState = ST_IDLE;
               else if (w_bitEnd)             w_nextState = ST_DATA;
            end
            ST_DATA: begin
               if (w_bitEnd && w_lastData) begin
                  if (PARITY_MODE != PARITY_NONE) w_nextState = ST_PARITY;
                  else                            w_nextState = ST_STOP;
               end
            end
            ST_PARITY: begin
               if (w_bitEnd) w_nextState = ST_STOP;
            end
            ST_STOP: begin
               if (w_bitStrobe && w_lastStop) begin
                  w_nextState = ST_IDLE;
                  w_complete  = 1'b1;
               end
            end
            default: w_nextState = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_bitCount  <= '0;
         r_stopCount <= 1'b0;
         r_shift     <= '0;
         r_parBit    <= 1'b0;
         r_parErr    <= 1'b0;
         r_frameErr  <= 1'b0;
      end else if (r_state == ST_IDLE) begin
         r_bitCount  <= '0;
         r_stopCount <= 1'b0;
         r_parErr    <= 1'b0;
         r_frameErr  <= 1'b0;
      end else begin
         if (r_state == ST_DATA) begin
            if (w_bitStrobe) r_shift <= {w_bitValue, r_shift[DATA_BITS-1:1]};
            if (w_bitEnd)    r_bitCount <= r_bitCount + 1'b1;
         end
         if ((r_state == ST_PARITY) && w_bitStrobe) begin
            r_parBit <= w_bitValue;
            r_parErr <= (w_bitValue != w_expParity);
         end
         if (r_state == ST_STOP) begin
            if (w_bitStrobe && !w_bitValue) r_frameErr <= 1'b1;
            if (w_bitEnd)                   r_stopCount <= r_stopCount + 1'b1;
         end
      end
   end

   // A line stuck low after a framing error must go high before the next start.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_needHigh <= 1'b0;
      end else if (w_complete && w_frameErrNow) begin
         r_needHigh <= 1'b1;
      end else if (w_rxSync) begin
         r_needHigh <= 1'b0;
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_rxData        <= '0;
         r_rxValid       <= 1'b0;
         r_rxParityError <= 1'b0;
         r_rxFrameError  <= 1'b0;
         r_rxBreak       <= 1'b0;
         r_rxOverrun     <= 1'b0;
      end else begin
         if (w_load) begin
            r_rxData        <= r_shift;
            r_rxValid       <= 1'b1;
            r_rxParityError <= r_parErr;
            r_rxFrameError  <= w_frameErrNow;
            r_rxBreak       <= w_breakNow;
         end else if (r_rxValid && RxReady) begin
            r_rxValid <= 1'b0;
         end
         if (w_complete && !w_load) begin
            r_rxOverrun <= 1'b1;
         end else if (RxErrorClear) begin
            r_rxOverrun <= 1'b0;
         end
      end
   end

   assign RxData        = r_rxData;
   assign RxValid       = r_rxValid;
   assign RxParityError = r_rxParityError;
   assign RxFrameError  = r_rxFrameError;
   assign RxBreak       = r_rxBreak;
   assign RxOverrun     = r_rxOverrun;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: an 8N1 instance and a 7-bit odd-parity
// two-stop instance, both at 160 clocks per bit.
module tb_uart_rx_cfg;

   localparam int BIT_CLKS = 160;

   logic       clk = 1'b0;
   logic       rstN;

   logic       line8, enable8, ready8, clear8;
   logic [7:0] data8;
   logic       valid8, par8, frame8, brk8, ovr8;

   logic       line7, enable7, ready7, clear7;
   logic [6:0] data7;
   logic       valid7, par7, frame7, brk7, ovr7;

   int         checkCount = 0;
   int         failCount  = 0;

   int         words8 = 0;
   int         validCyc8 = 0;
   logic [7:0] capData8 = '0;
   logic       capPar8 = 1'b0, capFrame8 = 1'b0, capBrk8 = 1'b0;
   logic       prev8 = 1'b0;

   int         words7 = 0;
   logic [6:0] capData7 = '0;
   logic       capPar7 = 1'b0, capFrame7 = 1'b0;
   logic       prev7 = 1'b0;

   int         w0;
   int         c0;

   always #5 clk = ~clk;

   uart_rx_cfg #(
      .CLOCK_FREQUENCY (1_536_000),
      .BAUD_RATE       (9600),
      .OVERSAMPLE      (16),
      .DATA_BITS       (8),
      .PARITY_MODE     (0),
      .STOP_BITS       (1)
   ) dut8 (
      .Clk           (clk),
      .Reset         (rstN),
      .RxWire        (line8),
      .RxEnable      (enable8),
      .RxData        (data8),
      .RxValid       (valid8),
      .RxReady       (ready8),
      .RxParityError (par8),
      .RxFrameError  (frame8),
      .RxBreak       (brk8),
      .RxOverrun     (ovr8),
      .RxErrorClear  (clear8)
   );

   uart_rx_cfg #(
      .CLOCK_FREQUENCY (1_536_000),
      .BAUD_RATE       (9600),
      .OVERSAMPLE      (16),
      .DATA_BITS       (7),
      .PARITY_MODE     (2),
      .STOP_BITS       (2)
   ) dut7 (
      .Clk           (clk),
      .Reset         (rstN),
      .RxWire        (line7),
      .RxEnable      (enable7),
      .RxData        (data7),
      .RxValid       (valid7),
      .RxReady       (ready7),
      .RxParityError (par7),
      .RxFrameError  (frame7),
      .RxBreak       (brk7),
      .RxOverrun     (ovr7),
      .RxErrorClear  (clear7)
   );

   // Capture each word as RxValid rises and measure how long it stays high.
   always @(negedge clk) begin
      if (valid8 && !prev8) begin
         words8++;
         capData8  = data8;
         capPar8   = par8;
         capFrame8 = frame8;
         capBrk8   = brk8;
      end
      if (valid8) validCyc8++;
      prev8 = valid8;
      if (valid7 && !prev7) begin
         words7++;
         capData7  = data7;
         capPar7   = par7;
         capFrame7 = frame7;
      end
      prev7 = valid7;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic driveBit(input bit sel7, input logic v);
      if (sel7) line7 = v;
      else      line8 = v;
      waitCycles(BIT_CLKS);
   endtask

   // Sends start, data LSB first, optional parity and stop bits; the line is
   // left at the last stop value.
   task automatic applyStimulus(input bit sel7, input logic [8:0] data,
                                input int nBits, input bit hasParity,
                                input logic parityBit, input int nStop,
                                input logic stopVal);
      driveBit(sel7, 1'b0);
      for (int i = 0; i < nBits; i++) driveBit(sel7, data[i]);
      if (hasParity) driveBit(sel7, parityBit);
      for (int i = 0; i < nStop; i++) driveBit(sel7, stopVal);
   endtask

   initial begin
      line8 = 1'b1; enable8 = 1'b1; ready8 = 1'b1; clear8 = 1'b0;
      line7 = 1'b1; enable7 = 1'b1; ready7 = 1'b1; clear7 = 1'b0;
      rstN  = 1'b0;
      waitCycles(5);
      checkOutput("reset valid8", 32'(valid8), 0);
      checkOutput("reset data8", 32'(data8), 0);
      checkOutput("reset flags8", 32'({par8, frame8, brk8, ovr8}), 0);
      checkOutput("reset valid7", 32'(valid7), 0);
      rstN = 1'b1;
      waitCycles(20);

      $display("[TB] 8N1 0xA5 with ready high");
      w0 = words8; c0 = validCyc8;
      applyStimulus(1'b0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1);
      waitCycles(40);
      checkOutput("a5 words", words8 - w0, 1);
      checkOutput("a5 data", 32'(capData8), 'hA5);
      checkOutput("a5 valid width", validCyc8 - c0, 1);
      checkOutput("a5 flags", 32'({capPar8, capFrame8, capBrk8, ovr8}), 0);

      $display("[TB] 7O2 0x3C good then bad parity");
      w0 = words7;
      applyStimulus(1'b1, 9'h03C, 7, 1'b1, 1'b1, 2, 1'b1);
      waitCycles(40);
      checkOutput("odd good words", words7 - w0, 1);
      checkOutput("odd good data", 32'(capData7), 'h3C);
      checkOutput("odd good parity", 32'(capPar7), 0);
      checkOutput("odd good frame", 32'(capFrame7), 0);
      applyStimulus(1'b1, 9'h03C, 7, 1'b1, 1'b0, 2, 1'b1);
      waitCycles(40);
      checkOutput("odd bad words", words7 - w0, 2);
      checkOutput("odd bad data", 32'(capData7), 'h3C);
      checkOutput("odd bad parity", 32'(capPar7), 1);

      $display("[TB] idle glitch then 0x55");
      w0 = words8;
      line8 = 1'b0;
      waitCycles(40);
      line8 = 1'b1;
      waitCycles(300);
      checkOutput("glitch words", words8 - w0, 0);
      applyStimulus(1'b0, 9'h055, 8, 1'b0, 1'b0, 1, 1'b1);
      waitCycles(40);
      checkOutput("post glitch words", words8 - w0, 1);
      checkOutput("post glitch data", 32'(capData8), 'h55);

      $display("[TB] overrun with ready low");
      ready8 = 1'b0;
      w0 = words8;
      applyStimulus(1'b0, 9'h011, 8, 1'b0, 1'b0, 1, 1'b1);
      applyStimulus(1'b0, 9'h022, 8, 1'b0, 1'b0, 1, 1'b1);
      waitCycles(40);
      checkOutput("overrun words", words8 - w0, 1);
      checkOutput("overrun held data", 32'(data8), 'h11);
      checkOutput("overrun valid", 32'(valid8), 1);
      checkOutput("overrun flag", 32'(ovr8), 1);
      clear8 = 1'b1;
      waitCycles(1);
      clear8 = 1'b0;
      waitCycles(2);
      checkOutput("overrun cleared", 32'(ovr8), 0);
      ready8 = 1'b1;
      waitCycles(2);
      checkOutput("drained valid", 32'(valid8), 0);

      $display("[TB] break condition");
      w0 = words8;
      applyStimulus(1'b0, 9'h000, 8, 1'b0, 1'b0, 1, 1'b0);
      waitCycles(19 * BIT_CLKS);
      checkOutput("break words", words8 - w0, 1);
      checkOutput("break data", 32'(capData8), 0);
      checkOutput("break frame", 32'(capFrame8), 1);
      checkOutput("break flag", 32'(capBrk8), 1);
      line8 = 1'b1;
      waitCycles(400);
      checkOutput("break no extra", words8 - w0, 1);
      applyStimulus(1'b0, 9'h03A, 8, 1'b0, 1'b0, 1, 1'b1);
      waitCycles(40);
      checkOutput("recover words", words8 - w0, 2);
      checkOutput("recover data", 32'(capData8), 'h3A);
      checkOutput("recover flags", 32'({capFrame8, capBrk8}), 0);

      $display("[TB] reset mid frame");
      driveBit(1'b0, 1'b0);
      driveBit(1'b0, 1'b0);
      driveBit(1'b0, 1'b0);
      driveBit(1'b0, 1'b0);
      waitCycles(50);
      rstN = 1'b0;
      #1;
      checkOutput("midreset data", 32'(data8), 0);
      checkOutput("midreset valid", 32'(valid8), 0);
      checkOutput("midreset flags", 32'({par8, frame8, brk8, ovr8}), 0);
      line8 = 1'b1;
      waitCycles(10);
      rstN = 1'b1;
      waitCycles(20);
      w0 = words8;
      applyStimulus(1'b0, 9'h00F, 8, 1'b0, 1'b0, 1, 1'b1);
      waitCycles(40);
      checkOutput("after reset words", words8 - w0, 1);
      checkOutput("after reset data", 32'(capData8), 'h0F);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
